// File: rtl/aibcr3_drvleg_pkg.sv
// Shared types and helpers for the ramped driver-leg decoder.
//   state_e : ramp controller states
//   therm() : binary leg count -> thermometer vector (LSB-first)
package aibcr3_drvleg_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_e;

  // Widest leg vector therm() can build; callers size the result down.
  localparam int unsigned MAX_LEGS = 64;

  // Bit k is set iff k < count, limited to the first 'legs' bits.
  function automatic logic [MAX_LEGS-1:0] therm(input int unsigned count,
                                                input int unsigned legs);
    logic [MAX_LEGS-1:0] vec;
    vec = '0;
    for (int unsigned k = 0; k < MAX_LEGS; k++) begin
      if ((k < count) && (k < legs)) vec[k] = 1'b1;
    end
    return vec;
  endfunction

endpackage

// File: rtl/aibcr3_drvleg_ramp_dec_if.sv
// Control/status bundle between strength CSR logic and the leg decoder.
//   enable, load, nsel_code, psel_code : from the controller
//   ready, done, nsel_outb, psel_out   : from the decoder
interface aibcr3_drvleg_ramp_dec_if #(
  parameter int unsigned CODE_W = 2
);
  localparam int unsigned LEGS = 1 << CODE_W;

  logic              enable;
  logic              load;
  logic [CODE_W-1:0] nsel_code;
  logic [CODE_W-1:0] psel_code;
  logic              ready;
  logic              done;
  logic [LEGS-1:0]   nsel_outb;
  logic [LEGS-1:0]   psel_out;

  modport master (
    output enable, load, nsel_code, psel_code,
    input  ready, done, nsel_outb, psel_out
  );

  modport slave (
    input  enable, load, nsel_code, psel_code,
    output ready, done, nsel_outb, psel_out
  );

endinterface

// File: rtl/aibcr3_drvleg_stepper.sv
// One side's leg counter: moves one leg toward tgt_i per step strobe and
// drives the registered thermometer leg enables.
//   clk, reset : clock, synchronous active-high reset
//   clr_i      : force all legs off immediately (takes priority)
//   step_i     : advance one leg toward tgt_i
//   tgt_i      : target number of legs on (0..LEGS)
//   cnt_o      : current number of legs on
//   legs_o     : leg enables, inverted when ACT_LOW=1
module aibcr3_drvleg_stepper
  import aibcr3_drvleg_pkg::*;
#(
  parameter int unsigned CODE_W  = 2,
  parameter bit          ACT_LOW = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr_i,
  input  logic                     step_i,
  input  logic [CODE_W:0]          tgt_i,
  output logic [CODE_W:0]          cnt_o,
  output logic [(1 << CODE_W)-1:0] legs_o
);

  localparam int unsigned LEGS  = 1 << CODE_W;
  localparam int unsigned CNT_W = CODE_W + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEGS-1:0]  legs_q, legs_d;

  // Next count; leg vector is built from it so outputs track the counter.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (step_i) begin
      if (cnt_q < tgt_i)      cnt_d = cnt_q + CNT_W'(1);
      else if (cnt_q > tgt_i) cnt_d = cnt_q - CNT_W'(1);
    end
    legs_d = LEGS'(therm(32'(cnt_d), LEGS)) ^ {LEGS{ACT_LOW}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      legs_q <= {LEGS{ACT_LOW}};
    end else begin
      cnt_q  <= cnt_d;
      legs_q <= legs_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign legs_o = legs_q;

endmodule

// File: rtl/aibcr3_drvleg_ramp_dec.sv
// Ramped N/P driver-strength decoder: binary strength codes become
// thermometer leg enables, changed one leg per STEP_CYC cycles to limit di/dt.
//   clk, reset : clock, synchronous active-high reset
//   bus        : enable/load/codes in; ready/done/nsel_outb/psel_out out
module aibcr3_drvleg_ramp_dec
  import aibcr3_drvleg_pkg::*;
#(
  parameter int unsigned CODE_W   = 2,
  parameter int unsigned STEP_CYC = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  aibcr3_drvleg_ramp_dec_if.slave  bus
);

  localparam int unsigned LEGS  = 1 << CODE_W;
  localparam int unsigned CNT_W = CODE_W + 1;
  localparam int unsigned TMR_W = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;

  state_e            state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [CODE_W-1:0] tgt_n_q, tgt_n_d, tgt_p_q, tgt_p_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  cur_n, cur_p, tn, tp;
  logic [LEGS-1:0]   nsel_outb_w, psel_out_w;
  logic              ready_w, accept, at_tgt, step, clr;

  // True when one step (or none) brings a onto b.
  function automatic logic within_one(input logic [CNT_W-1:0] a,
                                      input logic [CNT_W-1:0] b);
    return (a == b) || ((a + CNT_W'(1)) == b) || ((b + CNT_W'(1)) == a);
  endfunction

  assign ready_w = (state_q == IDLE) & ~reset;
  assign accept  = bus.load & ready_w;

  // Codes captured only on acceptance; code k means k+1 legs when enabled.
  always_comb begin
    tgt_n_d = accept ? bus.nsel_code : tgt_n_q;
    tgt_p_d = accept ? bus.psel_code : tgt_p_q;
    tn      = bus.enable ? (CNT_W'(tgt_n_d) + CNT_W'(1)) : '0;
    tp      = bus.enable ? (CNT_W'(tgt_p_d) + CNT_W'(1)) : '0;
    at_tgt  = (cur_n == tn) && (cur_p == tp);
  end

  // Ramp controller; enable low is an immediate all-off override.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    done_d  = 1'b0;
    step    = 1'b0;
    clr     = 1'b0;
    if (!bus.enable) begin
      clr     = 1'b1;
      state_d = IDLE;
      tmr_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          tmr_d = '0;
          if (accept || !at_tgt) state_d = RAMP;
          // A load that changes nothing still reports completion.
          done_d = accept && at_tgt;
        end
        RAMP: begin
          if (at_tgt) begin
            state_d = IDLE;
            tmr_d   = '0;
          end else if (tmr_q == '0) begin
            step   = 1'b1;
            tmr_d  = TMR_W'(STEP_CYC - 1);
            done_d = within_one(cur_n, tn) && within_one(cur_p, tp);
          end else begin
            tmr_d = tmr_q - TMR_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      tgt_n_q <= '0;
      tgt_p_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      tgt_n_q <= tgt_n_d;
      tgt_p_q <= tgt_p_d;
      done_q  <= done_d;
    end
  end

  aibcr3_drvleg_stepper #(.CODE_W(CODE_W), .ACT_LOW(1'b1)) u_step_n (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (clr),
    .step_i (step),
    .tgt_i  (tn),
    .cnt_o  (cur_n),
    .legs_o (nsel_outb_w)
  );

  aibcr3_drvleg_stepper #(.CODE_W(CODE_W), .ACT_LOW(1'b0)) u_step_p (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (clr),
    .step_i (step),
    .tgt_i  (tp),
    .cnt_o  (cur_p),
    .legs_o (psel_out_w)
  );

  assign bus.ready     = ready_w;
  assign bus.done      = done_q;
  assign bus.nsel_outb = nsel_outb_w;
  assign bus.psel_out  = psel_out_w;

endmodule
